gpio_param_bank: RTL and testbench
==================================

// Module: gpio_param_bank
// PURPOSE
//  Registered, bidirectional successor to the combinational GPIO parameter mux. Decodes a GPIO
//  command word from the PS, reads/writes a bank of PARAM_COUNT config registers (driven to the
//  SPGD core on PARAMS_OUT) and reads back external status words (PARAMS_DATA). Toggle REQ/ACK
//  handshake; several banks share one GPIO pair, each selected by its own SET code.
// PARAMETERS
//  GPIO_WIDTH     32          GPIO word width; also width of every parameter
//  PARAM_COUNT    16          registers per space (internal and status), 1..16
//  TIMEOUT_CYCLES 1024        max CLK cycles waiting for the write data phase
//  RESET_VALUES   all zero    PARAM_COUNT*GPIO_WIDTH reset image of config registers
// PORTS
//  CLK          in   1                      system clock
//  RST          in   1                      synchronous, active-high reset
//  GP_IN        in   GPIO_WIDTH             command/data word from PS
//  SET          in   4                      this bank's set code
//  PARAMS_DATA  in   PARAM_COUNT*GPIO_WIDTH status words (read-only space)
//  GP_OUT       out  GPIO_WIDTH             read data
//  GP_ACK       out  1                      toggles once per completed phase
//  CMD_ERR      out  1                      error flag of last transaction
//  PARAMS_OUT   out  PARAM_COUNT*GPIO_WIDTH config registers
//  PARAM_UPDATE out  1                      1-cycle pulse when PARAMS_OUT changes
// BEHAVIOUR
//  Command word (W=GPIO_WIDTH): [W-1] REQ toggle, [W-2] WR, [W-3] EN, [W-4] SPACE (0 cfg, 1 status),
//   [W-5:W-8] SET, [3:0] IDX. Data word (write phase 2): all W bits are data; REQ still at [W-1]
//   only as toggle -> data value is the full word, REQ bit included.
//  GP_IN passes a 2-FF synchroniser; a request = synced REQ differs from last-seen REQ.
//   Latency: GP_ACK toggles on 3rd CLK edge after the first edge sampling the new REQ level.
//   Host holds GP_IN stable until GP_ACK toggles.
//  Request ignored entirely (no ACK, no state change) if EN=0 or SET!=SET input; last-seen REQ
//   still updates so the next toggle is new.
//  FSM: IDLE -> EXEC on accepted request. EXEC (1 cycle):
//   read: GP_OUT<=selected word, CMD_ERR<=0, toggle ACK -> IDLE.
//   write cfg: toggle ACK, clear timer -> WAIT_DATA.
//   IDX>=PARAM_COUNT: GP_OUT<=0, CMD_ERR<=1, toggle ACK -> IDLE (write not entered).
//   write SPACE=1: see CONFIGURATION.
//  WAIT_DATA: next accepted toggle (EN/SET not checked) -> cfg[IDX]<=word, PARAM_UPDATE pulse,
//   CMD_ERR<=0, toggle ACK -> IDLE. Timer hits TIMEOUT_CYCLES-1 -> CMD_ERR<=1, no ACK, -> IDLE.
//  GP_OUT holds until next read. Only one transaction in flight; no queueing.
//  Reset: GP_OUT=0, GP_ACK=0, CMD_ERR=0, PARAM_UPDATE=0, PARAMS_OUT=RESET_VALUES, sync and
//   last-seen REQ=0, FSM IDLE, timer 0. Reset in WAIT_DATA aborts; pending data dropped.
//   Host must drive REQ=0 during reset; a REQ=1 after reset is a real request.
// CONFIGURATION
//  PARAM_SHADOW_EN defined: cfg writes land in a shadow bank; write with SPACE=1 (any IDX) is
//   COMMIT: PARAMS_OUT<=shadow atomically, PARAM_UPDATE pulse, ACK, no data phase. Reads of
//   SPACE=0 return shadow. Reset loads both banks with RESET_VALUES.
//  Undefined: writes update PARAMS_OUT directly in WAIT_DATA; write with SPACE=1 ->
//   CMD_ERR=1, ACK, no change.
// STRUCTURE
//  Package gpio_param_pkg: command-bit position localparams (REQ/WR/EN/SPACE/SET/IDX), state
//   enum {IDLE, EXEC, WAIT_DATA}, timer width function.
//  Sub-module gpio_req_sync: 2-FF synchroniser of GP_IN + REQ toggle detect, emits req pulse.
// TESTING
//  Read cfg: RST, REQ 0->1, EN=1,SET=5=SET,IDX=3,SPACE=0 -> ACK toggles 3 cycles later, GP_OUT=RESET_VALUES[3].
//  Write: cmd WR=1 IDX=2, then data 0x1234_5678 with toggle -> PARAMS_OUT[2]=0x12345678, 1 UPDATE pulse.
//  Foreign set: SET=5, cmd SET=6 -> no ACK, no change; next matching toggle served normally.
//  Range: IDX=15 with PARAM_COUNT=8 read -> GP_OUT=0, CMD_ERR=1, ACK toggles.
//  Timeout: write cmd, no data for TIMEOUT_CYCLES -> CMD_ERR=1, FSM IDLE, PARAMS_OUT unchanged.
//  Shadow (PARAM_SHADOW_EN): write IDX=1 -> PARAMS_OUT unchanged; COMMIT -> PARAMS_OUT[1] updated, 1 pulse.

Source files
------------

// File: rtl/gpio_param_pkg.sv
// Shared definitions for the GPIO parameter bank: command-word field
// positions (as offsets from the MSB, so they work for any GPIO width),
// the controller state encoding and the timeout-timer width helper.
package gpio_param_pkg;

    // Field offsets counted down from the MSB of the command word
    localparam int REQ_OFS     = 1;
    localparam int WR_OFS      = 2;
    localparam int EN_OFS      = 3;
    localparam int SPACE_OFS   = 4;
    localparam int SET_MSB_OFS = 5;
    localparam int SET_W       = 4;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        EXEC      = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    // Bits needed to count 0 .. cycles-1
    function automatic int tmr_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/gpio_req_sync.sv
// Two-flop synchroniser for the PS GPIO word plus REQ toggle detection.
// o_req is high for one cycle whenever the synchronised REQ bit differs
// from the last level seen; the last-seen level follows unconditionally.
module gpio_req_sync #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [GPIO_WIDTH-1:0] i_gp,
    output logic [GPIO_WIDTH-1:0] o_word,
    output logic                  o_req
);

    logic [GPIO_WIDTH-1:0] r_s1;
    logic [GPIO_WIDTH-1:0] r_s2;
    logic                  r_last_req;

    // Synchronise the whole word and remember the last REQ level
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1       <= '0;
            r_s2       <= '0;
            r_last_req <= 1'b0;
        end else begin
            r_s1       <= i_gp;
            r_s2       <= r_s1;
            r_last_req <= r_s2[GPIO_WIDTH-1];
        end
    end

    assign o_word = r_s2;
    assign o_req  = r_s2[GPIO_WIDTH-1] ^ r_last_req;

endmodule

// File: rtl/gpio_param_bank.sv
// Registered GPIO parameter bank with toggle REQ/ACK handshake.
// Optional build macro: PARAM_SHADOW_EN -- config writes go to a shadow
// bank and a write to SPACE=1 commits the shadow to PARAMS_OUT atomically.
// Without it, writes update PARAMS_OUT directly and SPACE=1 writes error.
//
//  state     | meaning
//  IDLE      | waiting for a request addressed to this bank
//  EXEC      | one cycle: serve read / commit / error, or arm write
//  WAIT_DATA | waiting for the data-phase toggle, timer running
module gpio_param_bank
    import gpio_param_pkg::*;
#(
    parameter int GPIO_WIDTH     = 32,
    parameter int PARAM_COUNT    = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [PARAM_COUNT*GPIO_WIDTH-1:0] RESET_VALUES = '0
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [GPIO_WIDTH-1:0]             GP_IN,
    input  logic [3:0]                        SET,
    input  logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_DATA,
    output logic [GPIO_WIDTH-1:0]             GP_OUT,
    output logic                              GP_ACK,
    output logic                              CMD_ERR,
    output logic [PARAM_COUNT*GPIO_WIDTH-1:0] PARAMS_OUT,
    output logic                              PARAM_UPDATE
);

    localparam int P_WR     = GPIO_WIDTH - WR_OFS;
    localparam int P_EN     = GPIO_WIDTH - EN_OFS;
    localparam int P_SPACE  = GPIO_WIDTH - SPACE_OFS;
    localparam int P_SET_HI = GPIO_WIDTH - SET_MSB_OFS;
    localparam int TW       = tmr_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W:0] P_CNT   = (IDX_W + 1)'(PARAM_COUNT);

    logic [GPIO_WIDTH-1:0] w_word;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_idx_oor;
    logic [GPIO_WIDTH-1:0] w_rd_cfg;
    logic [GPIO_WIDTH-1:0] w_rd_stat;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wr;
    logic                  r_space;
    logic [IDX_W-1:0]      r_idx;
    logic [TW-1:0]         r_tmr;
    logic [GPIO_WIDTH-1:0] r_gp_out;
    logic                  r_ack;
    logic                  r_err;
    logic                  r_upd;
    logic [GPIO_WIDTH-1:0] r_cfg [PARAM_COUNT];

    logic                  w_latch;
    logic                  w_ack_tgl;
    logic                  w_rd_load;
    logic [GPIO_WIDTH-1:0] w_rd_val;
    logic                  w_err_set;
    logic                  w_err_clr;
    logic                  w_cfg_wr;
    logic                  w_upd;
    logic                  w_tmr_clr;
`ifdef PARAM_SHADOW_EN
    logic                  w_commit;
    logic [GPIO_WIDTH-1:0] r_shadow [PARAM_COUNT];
`endif

    gpio_req_sync #(
        .GPIO_WIDTH (GPIO_WIDTH)
    ) u_sync (
        .i_clk  (CLK),
        .i_rst  (RST),
        .i_gp   (GP_IN),
        .o_word (w_word),
        .o_req  (w_req)
    );

    assign w_accept  = w_req && w_word[P_EN] && (w_word[P_SET_HI -: SET_W] == SET);
    assign w_idx_oor = ({1'b0, r_idx} >= P_CNT);

    // Read muxes: config (or shadow) space and external status space
    always_comb begin
        w_rd_cfg  = '0;
        w_rd_stat = '0;
        for (int i = 0; i < PARAM_COUNT; i++) begin
            if (r_idx == IDX_W'(i)) begin
`ifdef PARAM_SHADOW_EN
                w_rd_cfg  = r_shadow[i];
`else
                w_rd_cfg  = r_cfg[i];
`endif
                w_rd_stat = PARAMS_DATA[i*GPIO_WIDTH +: GPIO_WIDTH];
            end
        end
    end

    // Controller state register
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_ack_tgl   = 1'b0;
        w_rd_load   = 1'b0;
        w_rd_val    = '0;
        w_err_set   = 1'b0;
        w_err_clr   = 1'b0;
        w_cfg_wr    = 1'b0;
        w_upd       = 1'b0;
        w_tmr_clr   = 1'b0;
`ifdef PARAM_SHADOW_EN
        w_commit    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_latch     = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_ack_tgl   = 1'b1;
                w_state_nxt = IDLE;
                if (r_wr && r_space) begin
`ifdef PARAM_SHADOW_EN
                    w_commit  = 1'b1;
                    w_upd     = 1'b1;
                    w_err_clr = 1'b1;
`else
                    w_err_set = 1'b1;
`endif
                end else if (w_idx_oor) begin
                    w_rd_load = 1'b1;
                    w_rd_val  = '0;
                    w_err_set = 1'b1;
                end else if (r_wr) begin
                    w_tmr_clr   = 1'b1;
                    w_state_nxt = WAIT_DATA;
                end else begin
                    w_rd_load = 1'b1;
                    w_rd_val  = r_space ? w_rd_stat : w_rd_cfg;
                    w_err_clr = 1'b1;
                end
            end
            WAIT_DATA: begin
                // Data toggle wins over a coincident timeout
                if (w_req) begin
                    w_cfg_wr    = 1'b1;
`ifndef PARAM_SHADOW_EN
                    w_upd       = 1'b1;
`endif
                    w_err_clr   = 1'b1;
                    w_ack_tgl   = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_tmr == TMR_LAST) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Command latch, handshake and status outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr     <= 1'b0;
            r_space  <= 1'b0;
            r_idx    <= '0;
            r_gp_out <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_upd    <= 1'b0;
        end else begin
            r_upd <= w_upd;
            if (w_latch) begin
                r_wr    <= w_word[P_WR];
                r_space <= w_word[P_SPACE];
                r_idx   <= w_word[IDX_W-1:0];
            end
            if (w_ack_tgl) r_ack <= ~r_ack;
            if (w_rd_load) r_gp_out <= w_rd_val;
            if (w_err_set)      r_err <= 1'b1;
            else if (w_err_clr) r_err <= 1'b0;
        end
    end

    // Data-phase timeout timer, counts only while waiting for data
    always_ff @(posedge CLK) begin
        if (RST || w_tmr_clr)         r_tmr <= '0;
        else if (r_state == WAIT_DATA) r_tmr <= r_tmr + 1'b1;
    end

    // Live configuration bank driving PARAMS_OUT
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PARAM_COUNT; i++)
                r_cfg[i] <= RESET_VALUES[i*GPIO_WIDTH +: GPIO_WIDTH];
        end else begin
`ifdef PARAM_SHADOW_EN
            if (w_commit)
                for (int i = 0; i < PARAM_COUNT; i++)
                    r_cfg[i] <= r_shadow[i];
`else
            if (w_cfg_wr)
                for (int i = 0; i < PARAM_COUNT; i++)
                    if (r_idx == IDX_W'(i)) r_cfg[i] <= w_word;
`endif
        end
    end

`ifdef PARAM_SHADOW_EN
    // Shadow bank collects writes until the next commit
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PARAM_COUNT; i++)
                r_shadow[i] <= RESET_VALUES[i*GPIO_WIDTH +: GPIO_WIDTH];
        end else if (w_cfg_wr) begin
            for (int i = 0; i < PARAM_COUNT; i++)
                if (r_idx == IDX_W'(i)) r_shadow[i] <= w_word;
        end
    end
`endif

    for (genvar g = 0; g < PARAM_COUNT; g++) begin : g_out
        assign PARAMS_OUT[g*GPIO_WIDTH +: GPIO_WIDTH] = r_cfg[g];
    end

    assign GP_OUT       = r_gp_out;
    assign GP_ACK       = r_ack;
    assign CMD_ERR      = r_err;
    assign PARAM_UPDATE = r_upd;

endmodule

// File: tb/tb_gpio_param_bank.sv
// Scoreboard bench for gpio_param_bank (default build, PARAM_COUNT=8,
// TIMEOUT_CYCLES=64). Each request that should be acknowledged pushes its
// expected GP_OUT, CMD_ERR and ACK latency; a negedge monitor pops and
// compares on every GP_ACK toggle.
module tb_gpio_param_bank;

    localparam int W   = 32;
    localparam int N   = 8;
    localparam int TMO = 64;
    localparam logic [N*W-1:0] RV = {
        32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
        32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000
    };

    logic           CLK = 1'b0;
    logic           RST;
    logic [W-1:0]   GP_IN;
    logic [3:0]     SET;
    logic [N*W-1:0] PARAMS_DATA;
    logic [W-1:0]   GP_OUT;
    logic           GP_ACK;
    logic           CMD_ERR;
    logic [N*W-1:0] PARAMS_OUT;
    logic           PARAM_UPDATE;

    gpio_param_bank #(
        .GPIO_WIDTH     (W),
        .PARAM_COUNT    (N),
        .TIMEOUT_CYCLES (TMO),
        .RESET_VALUES   (RV)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .GP_IN        (GP_IN),
        .SET          (SET),
        .PARAMS_DATA  (PARAMS_DATA),
        .GP_OUT       (GP_OUT),
        .GP_ACK       (GP_ACK),
        .CMD_ERR      (CMD_ERR),
        .PARAMS_OUT   (PARAMS_OUT),
        .PARAM_UPDATE (PARAM_UPDATE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] gp;
        logic         err;
        int           lat;
        int           drv;
        int           tag;
    } exp_t;

    exp_t       sbq[$];
    int         checks   = 0;
    int         failures = 0;
    int         ack_cnt  = 0;
    int         upd_cnt  = 0;
    int         ack_cyc  = 0;
    logic       last_ack = 1'b0;
    logic       req      = 1'b0;
    logic [W-1:0] m_cfg [N];

    // Monitor: compare every ACK toggle against the head of the scoreboard
    always @(negedge CLK) begin
        exp_t e;
        if (PARAM_UPDATE) upd_cnt++;
        if (RST) begin
            last_ack = GP_ACK;
        end else if (GP_ACK !== last_ack) begin
            last_ack = GP_ACK;
            ack_cnt++;
            ack_cyc = cyc;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ack cyc=%0d gp_out=%h", cyc, GP_OUT);
            end else begin
                e = sbq.pop_front();
                checks++;
                if (GP_OUT !== e.gp) begin
                    failures++;
                    $display("FAIL gp_out tag=%0d got=%h exp=%h", e.tag, GP_OUT, e.gp);
                end
                checks++;
                if (CMD_ERR !== e.err) begin
                    failures++;
                    $display("FAIL cmd_err tag=%0d got=%b exp=%b", e.tag, CMD_ERR, e.err);
                end
                if (e.lat >= 0) begin
                    checks++;
                    if (cyc - e.drv != e.lat) begin
                        failures++;
                        $display("FAIL ack_latency tag=%0d got=%0d exp=%0d", e.tag, cyc - e.drv, e.lat);
                    end
                end
            end
        end
    end

    function automatic logic [W-1:0] cmd(input logic wr, input logic en, input logic space,
                                         input logic [3:0] set, input logic [3:0] idx);
        return {~req, wr, en, space, set, 20'd0, idx};
    endfunction

    function automatic logic [N*W-1:0] model_out();
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = m_cfg[i];
        return v;
    endfunction

    task automatic chk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic send(input logic [W-1:0] w, input bit push, input logic [W-1:0] gp,
                        input logic err, input int lat, input int tag);
        @(posedge CLK);
        #1;
        GP_IN = w;
        req   = w[W-1];
        if (push) sbq.push_back('{gp: gp, err: err, lat: lat, drv: cyc, tag: tag});
    endtask

    task automatic drain(input int tag);
        int n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL ack_timeout tag=%0d pending=%0d", tag, sbq.size());
            sbq.delete();
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        int acks0;
        int upd0;

        RST   = 1'b1;
        GP_IN = '0;
        SET   = 4'd5;
        for (int i = 0; i < N; i++) begin
            PARAMS_DATA[i*W +: W] = 32'hC0DE_0000 + i;
            m_cfg[i]              = 32'hA5A5_0000 + i;
        end
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);

        chk("rst_gp_out",  N*W'(GP_OUT),       '0);
        chk("rst_ack",     N*W'(GP_ACK),       '0);
        chk("rst_err",     N*W'(CMD_ERR),      '0);
        chk("rst_update",  N*W'(PARAM_UPDATE), '0);
        chk("rst_params",  PARAMS_OUT,         model_out());

        // Reads of config and status space
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd3), 1'b1, 32'hA5A5_0003, 1'b0, 4, 1);
        drain(1);
        send(cmd(1'b0, 1'b1, 1'b1, 4'd5, 4'd6), 1'b1, 32'hC0DE_0006, 1'b0, 4, 2);
        drain(2);

        // Write IDX=2 then data phase
        upd0 = upd_cnt;
        send(cmd(1'b1, 1'b1, 1'b0, 4'd5, 4'd2), 1'b1, 32'hC0DE_0006, 1'b0, 4, 3);
        drain(3);
        send(32'h1234_5678, 1'b1, 32'hC0DE_0006, 1'b0, -1, 4);
        drain(4);
        m_cfg[2] = 32'h1234_5678;
        chk("write_params", PARAMS_OUT, model_out());
        chk("write_update_pulses", N*W'(upd_cnt - upd0), N*W'(1));
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd2), 1'b1, 32'h1234_5678, 1'b0, 4, 5);
        drain(5);

        // Foreign set and EN=0 requests are ignored
        acks0 = ack_cnt;
        send(cmd(1'b0, 1'b1, 1'b0, 4'd6, 4'd1), 1'b0, '0, 1'b0, 0, 6);
        repeat (12) @(negedge CLK);
        send(cmd(1'b1, 1'b0, 1'b0, 4'd5, 4'd1), 1'b0, '0, 1'b0, 0, 7);
        repeat (12) @(negedge CLK);
        chk("ignored_no_ack", N*W'(ack_cnt - acks0), '0);
        chk("ignored_gp_out", N*W'(GP_OUT), N*W'(32'h1234_5678));
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd1), 1'b1, 32'hA5A5_0001, 1'b0, 4, 8);
        drain(8);

        // Index range: 15 and 8 are out of range, 7 is the last valid one
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd15), 1'b1, 32'h0, 1'b1, 4, 9);
        drain(9);
        send(cmd(1'b1, 1'b1, 1'b0, 4'd5, 4'd8), 1'b1, 32'h0, 1'b1, 4, 10);
        drain(10);
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd7), 1'b1, 32'hA5A5_0007, 1'b0, 4, 11);
        drain(11);

        // Write to status space is rejected without changing config
        upd0 = upd_cnt;
        send(cmd(1'b1, 1'b1, 1'b1, 4'd5, 4'd1), 1'b1, 32'hA5A5_0007, 1'b1, 4, 12);
        drain(12);
        chk("space1_params", PARAMS_OUT, model_out());
        chk("space1_no_update", N*W'(upd_cnt - upd0), '0);

        // Data-phase timeout
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd0), 1'b1, 32'hA5A5_0000, 1'b0, 4, 13);
        drain(13);
        upd0 = upd_cnt;
        send(cmd(1'b1, 1'b1, 1'b0, 4'd5, 4'd5), 1'b1, 32'hA5A5_0000, 1'b0, 4, 14);
        drain(14);
        acks0 = ack_cnt;
        while (cyc < ack_cyc + TMO - 1) @(negedge CLK);
        chk("timeout_not_early", N*W'(CMD_ERR), '0);
        @(negedge CLK);
        chk("timeout_err", N*W'(CMD_ERR), N*W'(1));
        chk("timeout_no_ack", N*W'(ack_cnt - acks0), '0);
        chk("timeout_params", PARAMS_OUT, model_out());
        chk("timeout_no_update", N*W'(upd_cnt - upd0), '0);
        send(cmd(1'b0, 1'b1, 1'b0, 4'd5, 4'd4), 1'b1, 32'hA5A5_0004, 1'b0, 4, 15);
        drain(15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
